writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are listed below as name, direction, width and meaning.
REQ-002 clk  input  1  rising-edge clock shared with the register file.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 stall_i  input  1  hold the MEM/WB register contents.
REQ-005 flush_i  input  1  load a bubble into the MEM/WB register.
REQ-006 m_valid  input  1  the MEM stage holds a real instruction.
REQ-007 m_reg_write  input  1  the instruction writes rd.
REQ-008 m_result_src  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
REQ-009 m_funct3  input  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-010 m_addr_lsb  input  2  byte offset of the load address, equal to alu_result[1:0].
REQ-011 m_alu_result, m_read_data, m_pc_plus4  input  32 each  candidate results.
REQ-012 m_rd  input  5  destination register index.
REQ-013 we3  output  1  register-file write enable.
REQ-014 a3  output  5  register-file write address.
REQ-015 wd3  output  32  register-file write data.
REQ-016 wb_valid  output  1  the WB register holds a real instruction.
REQ-017 retired_count  output  32  count of retired instructions.

Function
REQ-018 The MEM/WB register SHALL capture every m_* field on the rising clk edge, with priority rst > flush_i > stall_i > load.
REQ-019 When flush_i=1 at an edge, the valid and reg_write fields SHALL clear to 0; other fields are don't-care.
REQ-020 When stall_i=1 and flush_i=0 at an edge, all register fields SHALL hold their values.
REQ-021 Latency: inputs sampled at edge N SHALL drive we3/a3/wd3 combinationally after edge N, one cycle total.
REQ-022 we3 SHALL equal wb_valid AND wb_reg_write AND (a3 != 0); a write to x0 is never requested.
REQ-023 a3 SHALL equal the registered rd; wb_valid SHALL equal the registered valid.
REQ-024 wd3 for result_src 00 SHALL be the registered alu_result.
REQ-025 wd3 for result_src 10 SHALL be the registered pc_plus4.
REQ-026 wd3 for result_src 11 SHALL be 32'h0.
REQ-027 wd3 for result_src 01 SHALL be the extended load data per REQ-028 to REQ-031.
REQ-028 lb/lbu: the byte at read_data[8*lsb+7 : 8*lsb] SHALL be selected, then sign-extended (lb) or zero-extended (lbu).
REQ-029 lh/lhu: the halfword selected by lsb[1] SHALL be used, with lsb[0] ignored, then sign-extended (lh) or zero-extended (lhu).
REQ-030 lw: read_data SHALL pass unmodified, with lsb ignored.
REQ-031 Undefined funct3 values (011, 110, 111) SHALL be treated as lw.
REQ-032 retired_count SHALL increment by 1 at each edge where wb_valid=1 and stall_i=0, whether or not we3 is asserted.
REQ-033 retired_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-034 While stalled, we3/a3/wd3 SHALL stay constant; repeated writes of the same value are permitted.
REQ-035 When flush_i and stall_i are both 1, the flush SHALL win, and the instruction held before the flush SHALL still count if wb_valid=1 and stall_i=0 — since stall_i=1 here, it SHALL NOT count.

Reset
REQ-036 While rst=1, asynchronously: wb_valid=0, we3=0, a3=0, wd3=0, retired_count=0, and all register fields=0.
REQ-037 rst asserted mid-stall SHALL discard the held instruction with no write.
REQ-038 After rst deasserts, the first capture SHALL occur at the next rising edge.

Verification
REQ-039 ALU writeback: m_valid=1, reg_write=1, src=00, rd=5, alu=32'h1234_5678 -> after 1 edge, we3=1, a3=5, wd3=32'h1234_5678; retired_count goes 0 to 1 on the next edge.
REQ-040 Load extension: read_data=32'h80FF_7F01. lb lsb=3 -> 32'hFFFF_FF80; lbu lsb=2 -> 32'h0000_00FF; lh lsb=2 -> 32'hFFFF_80FF; lhu lsb=1 -> 32'h0000_7F01; funct3=111 -> 32'h80FF_7F01.
REQ-041 x0 suppression: rd=0, reg_write=1, valid=1 -> we3=0 and retired_count still increments.
REQ-042 Stall/flush: stall_i=1 for 3 edges -> outputs held and count unchanged; flush_i=1 with stall_i=1 -> wb_valid=0 and we3=0 next cycle.
REQ-043 Counter wrap: retired_count preset to 32'hFFFF_FFFF via a stream of retirements -> one more retirement gives 0.
REQ-044 Async reset: assert rst between edges while we3=1 -> we3, wb_valid, wd3 and retired_count go to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register plus writeback mux with load extension and a retired-instruction counter.
// Register-file write port signals are driven combinationally from the registered fields.
module writeback_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        m_valid,
    input  logic        m_reg_write,
    input  logic [1:0]  m_result_src,
    input  logic [2:0]  m_funct3,
    input  logic [1:0]  m_addr_lsb,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_read_data,
    input  logic [31:0] m_pc_plus4,
    input  logic [4:0]  m_rd,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3,
    output logic        wb_valid,
    output logic [31:0] retired_count
);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_LOAD = 2'b01,
        SRC_PC4  = 2'b10,
        SRC_RSVD = 2'b11
    } result_src_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        result_src_e result_src;
        logic [2:0]  funct3;
        logic [1:0]  addr_lsb;
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
    } mem_wb_t;

    mem_wb_t     wb_d, wb_q;
    logic [31:0] retired_count_d, retired_count_q;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wb_d = wb_q;
        if (flush_i) begin
            wb_d.valid     = 1'b0;
            wb_d.reg_write = 1'b0;
        end else if (!stall_i) begin
            wb_d.valid      = m_valid;
            wb_d.reg_write  = m_reg_write;
            wb_d.result_src = result_src_e'(m_result_src);
            wb_d.funct3     = m_funct3;
            wb_d.addr_lsb   = m_addr_lsb;
            wb_d.alu_result = m_alu_result;
            wb_d.read_data  = m_read_data;
            wb_d.pc_plus4   = m_pc_plus4;
            wb_d.rd         = m_rd;
        end
    end

    // The instruction sitting in WB retires whenever the stage is not stalled, flush or not.
    always_comb begin
        retired_count_d = retired_count_q;
        if (wb_q.valid && !stall_i) begin
            retired_count_d = retired_count_q + 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q            <= '0;
            retired_count_q <= '0;
        end else begin
            wb_q            <= wb_d;
            retired_count_q <= retired_count_d;
        end
    end

    always_comb begin
        load_byte = 8'h00;
        case (wb_q.addr_lsb)
            2'd0:    load_byte = wb_q.read_data[7:0];
            2'd1:    load_byte = wb_q.read_data[15:8];
            2'd2:    load_byte = wb_q.read_data[23:16];
            default: load_byte = wb_q.read_data[31:24];
        endcase
        load_half = wb_q.addr_lsb[1] ? wb_q.read_data[31:16] : wb_q.read_data[15:0];

        // Undefined funct3 encodings fall through to the full-word path.
        case (wb_q.funct3)
            F3_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            F3_LBU:  load_data = {24'h0, load_byte};
            F3_LH:   load_data = {{16{load_half[15]}}, load_half};
            F3_LHU:  load_data = {16'h0, load_half};
            default: load_data = wb_q.read_data;
        endcase
    end

    always_comb begin
        case (wb_q.result_src)
            SRC_ALU:  wd3 = wb_q.alu_result;
            SRC_LOAD: wd3 = load_data;
            SRC_PC4:  wd3 = wb_q.pc_plus4;
            default:  wd3 = 32'h0;
        endcase
    end

    assign we3           = wb_q.valid && wb_q.reg_write && (wb_q.rd != 5'd0);
    assign a3            = wb_q.rd;
    assign wb_valid      = wb_q.valid;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized stimulus
// compared against a behavioural model of the pipeline register and result selection.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i;
    logic        m_valid, m_reg_write;
    logic [1:0]  m_result_src;
    logic [2:0]  m_funct3;
    logic [1:0]  m_addr_lsb;
    logic [31:0] m_alu_result, m_read_data, m_pc_plus4;
    logic [4:0]  m_rd;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        wb_valid;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state: the instruction held in WB and the retirement count.
    logic        md_valid, md_rw;
    logic [1:0]  md_src;
    logic [2:0]  md_f3;
    logic [1:0]  md_lsb;
    logic [31:0] md_alu, md_rdat, md_pc;
    logic [4:0]  md_rd;
    logic [31:0] md_cnt;

    writeback_stage dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .m_valid(m_valid), .m_reg_write(m_reg_write), .m_result_src(m_result_src),
        .m_funct3(m_funct3), .m_addr_lsb(m_addr_lsb), .m_alu_result(m_alu_result),
        .m_read_data(m_read_data), .m_pc_plus4(m_pc_plus4), .m_rd(m_rd),
        .we3(we3), .a3(a3), .wd3(wd3), .wb_valid(wb_valid), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [1:0] lsb,
                                             input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * lsb)) & 32'hFF;
        h = (d >> (16 * lsb[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return b + ((b >= 32'd128) ? 32'hFFFF_FF00 : 32'h0);
            3'b100:  return b;
            3'b001:  return h + ((h >= 32'd32768) ? 32'hFFFF_0000 : 32'h0);
            3'b101:  return h;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_wd();
        case (md_src)
            2'b00:   return md_alu;
            2'b01:   return ext_load(md_f3, md_lsb, md_rdat);
            2'b10:   return md_pc;
            default: return 32'h0;
        endcase
    endfunction

    // {wb_valid, we3, a3, wd3, retired_count}; a3/wd3 are don't-care while WB is empty.
    function automatic logic [70:0] exp_vec();
        logic we;
        we = md_valid && md_rw && (md_rd != 5'd0);
        return {md_valid, we, md_valid ? md_rd : 5'd0, md_valid ? model_wd() : 32'd0, md_cnt};
    endfunction

    function automatic logic [70:0] obs_vec();
        return {wb_valid, we3, md_valid ? a3 : 5'd0, md_valid ? wd3 : 32'd0, retired_count};
    endfunction

    task automatic model_reset();
        {md_valid, md_rw, md_src, md_f3, md_lsb, md_alu, md_rdat, md_pc, md_rd, md_cnt} = '0;
    endtask

    task automatic tick();
        if (md_valid && !stall_i) md_cnt = md_cnt + 32'd1;
        if (flush_i) begin
            md_valid = 1'b0;
            md_rw    = 1'b0;
        end else if (!stall_i) begin
            md_valid = m_valid;      md_rw   = m_reg_write;  md_src = m_result_src;
            md_f3    = m_funct3;     md_lsb  = m_addr_lsb;   md_alu = m_alu_result;
            md_rdat  = m_read_data;  md_pc   = m_pc_plus4;   md_rd  = m_rd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rdat,
                         input logic [31:0] pc, input logic [4:0] rd);
        m_valid = v;  m_reg_write = rw;  m_result_src = src;  m_funct3 = f3;
        m_alu_result = alu;  m_addr_lsb = alu[1:0];  m_read_data = rdat;
        m_pc_plus4 = pc;  m_rd = rd;
    endtask

    task automatic drive_random();
        drive($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 3'($urandom),
              $urandom, $urandom, $urandom, 5'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;  stall_i = 1'b0;  flush_i = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 3'b010, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd4);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({wb_valid, we3, a3, wd3, retired_count} !== 71'd0) begin
            n_fails++;
            $display("FAIL reset_state: got %h, want 0", {wb_valid, we3, a3, wd3, retired_count});
        end
        model_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 5'd5);
        tick();
        n_checks++;
        if ({we3, a3, wd3, retired_count} !== {1'b1, 5'd5, 32'h1234_5678, 32'd0}) begin
            n_fails++;
            $display("FAIL alu_write: got we3=%b a3=%0d wd3=%h cnt=%0d, want 1 5 12345678 0",
                     we3, a3, wd3, retired_count);
        end
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        n_checks++;
        if (retired_count !== 32'd1) begin
            n_fails++;
            $display("FAIL alu_retire: got cnt=%0d, want 1", retired_count);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b111};
        logic [1:0]  lsbs [5] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd2};
        logic [31:0] want [5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                                  32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 2'b01, f3s[i], {30'h100, lsbs[i]}, 32'h80FF_7F01, 32'h0, 5'd7);
            tick();
            n_checks++;
            if (wd3 !== want[i] || we3 !== 1'b1) begin
                n_fails++;
                $display("FAIL load_ext[%0d]: got wd3=%h we3=%b, want %h 1", i, wd3, we3, want[i]);
            end
        end
    endtask

    task automatic test_x0();
        drive(1'b1, 1'b1, 2'b00, 3'b000, 32'hCAFE_0001, 32'h0, 32'h0, 5'd0);
        tick();
        n_checks++;
        if (we3 !== 1'b0 || wb_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL x0_suppress: got we3=%b wb_valid=%b, want 0 1", we3, wb_valid);
        end
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        n_checks++;
        if (retired_count !== md_cnt) begin
            n_fails++;
            $display("FAIL x0_retire: got cnt=%0d, want %0d", retired_count, md_cnt);
        end
    endtask

    task automatic test_stall_flush();
        logic [70:0] held;
        drive(1'b1, 1'b1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_4444, 5'd9);
        tick();
        held = exp_vec();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            tick();
            n_checks++;
            if (obs_vec() !== held) begin
                n_fails++;
                $display("FAIL stall_hold[%0d]: got %h, want %h", i, obs_vec(), held);
            end
        end
        flush_i = 1'b1;
        tick();
        n_checks++;
        if ({wb_valid, we3, retired_count} !== {2'b00, held[31:0]}) begin
            n_fails++;
            $display("FAIL flush_stall: got valid=%b we3=%b cnt=%0d, want 0 0 %0d",
                     wb_valid, we3, retired_count, held[31:0]);
        end
        flush_i = 1'b0;  stall_i = 1'b0;
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            drive_random();
            stall_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 9) == 0);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fails++;
                bad++;
                if (bad <= 10) $display("FAIL random[%0d]: got %h, want %h", i, obs_vec(), exp_vec());
            end
        end
        stall_i = 1'b0;  flush_i = 1'b0;
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        force dut.retired_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.retired_count_q;
        md_cnt = 32'hFFFF_FFFE;
        drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h11, 32'h0, 32'h0, 5'd1);
        tick();
        tick();
        n_checks++;
        if (retired_count !== 32'hFFFF_FFFF) begin
            n_fails++;
            $display("FAIL wrap_pre: got cnt=%h, want ffffffff", retired_count);
        end
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        n_checks++;
        if (retired_count !== 32'h0) begin
            n_fails++;
            $display("FAIL wrap: got cnt=%h, want 0", retired_count);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 2'b00, 3'b000, 32'h0BAD_F00D, 32'h0, 32'h0, 5'd3);
        tick();
        n_checks++;
        if (we3 !== 1'b1) begin
            n_fails++;
            $display("FAIL async_pre: got we3=%b, want 1", we3);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({wb_valid, we3, wd3, retired_count} !== 66'd0) begin
            n_fails++;
            $display("FAIL async_reset: got valid=%b we3=%b wd3=%h cnt=%0d, want all 0",
                     wb_valid, we3, wd3, retired_count);
        end
        #1;
        rst = 1'b0;
        model_reset();
        tick();
        // Reset arriving while an instruction is held by a stall must discard it.
        stall_i = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        stall_i = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
        tick();
        n_checks++;
        if ({wb_valid, we3, retired_count} !== 34'd0) begin
            n_fails++;
            $display("FAIL reset_in_stall: got valid=%b we3=%b cnt=%0d, want 0 0 0",
                     wb_valid, we3, retired_count);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_ext();
        test_x0();
        test_stall_flush();
        test_random();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
